// File: rtl/ka409_pkg.sv
// Shared constants and FSM state encoding for the shared 409-bit GF(2) multiplier scheduler.
package ka409_pkg;
    localparam int KA_N     = 409;
    localparam int KA_YW    = 817;
    localparam int KA_RED_K = 87;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/KA_409bit.sv
// Combinational 409x409 carry-less multiplier, one Karatsuba level over two schoolbook halves.
// Latency: purely combinational; the caller provides the multi-cycle window.
// Backpressure: none, no handshake.
module KA_409bit (
    input  logic [408:0] a,
    input  logic [408:0] b,
    output logic [816:0] y
);
    function automatic logic [408:0] clmul_lo(input logic [204:0] x, input logic [204:0] z);
        logic [408:0] acc;
        acc = '0;
        for (int i = 0; i < 205; i++)
            if (z[i]) acc ^= ({204'b0, x} << i);
        return acc;
    endfunction

    function automatic logic [406:0] clmul_hi(input logic [203:0] x, input logic [203:0] z);
        logic [406:0] acc;
        acc = '0;
        for (int i = 0; i < 204; i++)
            if (z[i]) acc ^= ({203'b0, x} << i);
        return acc;
    endfunction

    logic [408:0] z0;
    logic [406:0] z2;
    logic [408:0] zx;
    logic [408:0] zm;

    assign z0 = clmul_lo(a[204:0], b[204:0]);
    assign z2 = clmul_hi(a[408:205], b[408:205]);
    assign zx = clmul_lo(a[204:0] ^ {1'b0, a[408:205]}, b[204:0] ^ {1'b0, b[408:205]});
    // Over GF(2) the middle term needs no subtraction: xor removes both outer products.
    assign zm = zx ^ z0 ^ {2'b0, z2};

    assign y = {408'b0, z0} ^ {203'b0, zm, 205'b0} ^ {z2, 410'b0};
endmodule

// File: rtl/ka409_reduce.sv
// Reduces an 817-bit GF(2) product modulo x^409 + x^87 + 1 by two trinomial folds.
// Latency: combinational. Backpressure: none.
module ka409_reduce
    import ka409_pkg::*;
(
    input  logic [KA_YW-1:0] y_in,
    output logic [KA_YW-1:0] y_out
);
    localparam int HW = KA_YW - KA_N;
    localparam int OV = HW + KA_RED_K - KA_N;

    logic [HW-1:0]   h;
    logic [OV-1:0]   hi;
    logic [KA_N-1:0] r;

    assign h  = y_in[KA_YW-1:KA_N];
    // Bits of h*x^87 that land above x^408 need a second fold.
    assign hi = h[HW-1:HW-OV];

    assign r = y_in[KA_N-1:0]
             ^ {{(KA_N-HW){1'b0}}, h}
             ^ {h[HW-OV-1:0], {KA_RED_K{1'b0}}}
             ^ {{(KA_N-OV){1'b0}}, hi}
             ^ {{(KA_N-OV-KA_RED_K){1'b0}}, hi, {KA_RED_K{1'b0}}};

    assign y_out = {{(KA_YW-KA_N){1'b0}}, r};
endmodule

// File: rtl/ka409_mul_sched.sv
// Round-robin scheduler sharing one KA_409bit multiplier between two requesters (KA409_REDUCE_EN: reduce mod B-409).
// Latency: accept at e0, rsp_valid after e(MUL_CYCLES); one op per MUL_CYCLES+2 cycles.
// Backpressure: requests stall with ready low while busy; response payload held until rsp_ready.
module ka409_mul_sched
    import ka409_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [KA_N-1:0]  req0_a,
    input  logic [KA_N-1:0]  req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [KA_N-1:0]  req1_a,
    input  logic [KA_N-1:0]  req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [KA_YW-1:0] rsp_y,
    output logic             busy
);
    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic             last;
    logic [KA_N-1:0]  op_a;
    logic [KA_N-1:0]  op_b;
    logic             op_id;
    logic             grant0;
    logic             grant1;
    logic [KA_YW-1:0] prod;
    logic [KA_YW-1:0] cap_y;

    // On a tie the requester not served last wins; last=1 after reset favours requester 0.
    assign grant0 = req0_valid && (!req1_valid || last);
    assign grant1 = req1_valid && (!req0_valid || !last);

    assign req0_ready = !rst && (state == IDLE) && grant0;
    assign req1_ready = !rst && (state == IDLE) && grant1;
    assign busy       = (state != IDLE);

    KA_409bit u_mul (
        .a (op_a),
        .b (op_b),
        .y (prod)
    );

`ifdef KA409_REDUCE_EN
    ka409_reduce u_reduce (
        .y_in  (prod),
        .y_out (cap_y)
    );
`else
    assign cap_y = prod;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        op_a  <= grant0 ? req0_a : req1_a;
                        op_b  <= grant0 ? req0_b : req1_b;
                        op_id <= grant1;
                        last  <= grant1;
                        cnt   <= CNT_INIT;
                        state <= MUL;
                    end
                end
                MUL: begin
                    // Operands stay frozen here so the multi-cycle path settles before capture.
                    if (cnt == 4'd0) begin
                        rsp_y     <= cap_y;
                        rsp_id    <= op_id;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ka409_mul_sched.sv
// Bench for ka409_mul_sched: vector table, scoreboard on the response channel, corner-case sequences.
module tb_ka409_mul_sched;
    typedef struct {
        logic         id;
        logic [816:0] y;
    } exp_t;

    typedef struct {
        logic         id;
        logic [408:0] a;
        logic [408:0] b;
        logic [816:0] y;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [408:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [816:0] rsp_y;

    logic         l_valid     [2];
    logic         l_rdy0      [2];
    logic         l_rdy1      [2];
    logic         l_rsp_valid [2];
    logic         l_rsp_id    [2];
    logic [816:0] l_y         [2];
    logic         l_busy      [2];
    logic [408:0] l_a, l_b;
    logic         l_zero;
    logic [408:0] l_zero_op;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic glog[$];
    exp_t mon_e;
    vec_t vt[8];

    ka409_mul_sched #(.MUL_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
    );

    ka409_mul_sched #(.MUL_CYCLES(1)) dut_c1 (
        .clk(clk), .rst(rst),
        .req0_valid(l_valid[0]), .req0_ready(l_rdy0[0]), .req0_a(l_a), .req0_b(l_b),
        .req1_valid(l_zero), .req1_ready(l_rdy1[0]), .req1_a(l_zero_op), .req1_b(l_zero_op),
        .rsp_valid(l_rsp_valid[0]), .rsp_ready(1'b1), .rsp_id(l_rsp_id[0]), .rsp_y(l_y[0]), .busy(l_busy[0])
    );

    ka409_mul_sched #(.MUL_CYCLES(16)) dut_c16 (
        .clk(clk), .rst(rst),
        .req0_valid(l_valid[1]), .req0_ready(l_rdy0[1]), .req0_a(l_a), .req0_b(l_b),
        .req1_valid(l_zero), .req1_ready(l_rdy1[1]), .req1_a(l_zero_op), .req1_b(l_zero_op),
        .rsp_valid(l_rsp_valid[1]), .rsp_ready(1'b1), .rsp_id(l_rsp_id[1]), .rsp_y(l_y[1]), .busy(l_busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: schoolbook carry-less product, then bitwise long division by the trinomial.
    function automatic logic [816:0] ref_y(input logic [408:0] a, input logic [408:0] b);
        logic [816:0] y;
        y = '0;
        for (int i = 0; i < 409; i++)
            if (a[i]) y ^= ({408'b0, b} << i);
`ifdef KA409_REDUCE_EN
        for (int k = 816; k >= 409; k--) begin
            if (y[k]) begin
                y[k]            = 1'b0;
                y[k - 409]      = ~y[k - 409];
                y[k - 409 + 87] = ~y[k - 409 + 87];
            end
        end
`endif
        return y;
    endfunction

    task automatic chk(input string nm, input logic [816:0] act, input logic [816:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req1_valid)
                chki("one_ready", int'(req0_ready && req1_ready), 0);
            if (req0_valid && req0_ready) begin
                mon_e.id = 1'b0;
                mon_e.y  = ref_y(req0_a, req0_b);
                sb.push_back(mon_e);
                glog.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                mon_e.id = 1'b1;
                mon_e.y  = ref_y(req1_a, req1_b);
                sb.push_back(mon_e);
                glog.push_back(1'b1);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chki("sb_unexpected_rsp", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chki("sb_id", int'(rsp_id), int'(mon_e.id));
                    chk("sb_y", rsp_y, mon_e.y);
                end
            end
        end
    end

    task automatic wait_rdy(input logic id);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        chki("accept", int'(got), 1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input vec_t v, input int exp_lat);
        int n;
        if (v.id) begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b;
        end else begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b;
        end
        wait_rdy(v.id);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~v.a; req0_b = ~v.b; req1_a = ~v.a; req1_b = ~v.b;
        wait_rsp(n);
        chki("latency", n, exp_lat);
        chk("op_y", rsp_y, v.y);
        chki("op_id", int'(rsp_id), int'(v.id));
        @(posedge clk); #1;
    endtask

    task automatic lat_test(input int k, input int mc);
        int  n;
        logic got;
        l_valid[k] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = l_rdy0[k];
        end
        chki("lat_accept", int'(got), 1);
        @(posedge clk); #1;
        l_valid[k] = 1'b0;
        n = 0;
        while (!l_rsp_valid[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chki("lat_cycles", n, mc);
        chk("lat_y", l_y[k], 817'd5);
        chki("lat_id", int'(l_rsp_id[k]), 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        glog.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        l_valid[0] = 1'b0; l_valid[1] = 1'b0;
        l_a = 409'd3; l_b = 409'd3;
        l_zero = 1'b0; l_zero_op = '0;

        vt[0] = '{1'b0, 409'd3,  409'd3,  817'd5};
        vt[1] = '{1'b1, 409'd7,  409'd7,  817'd21};
        vt[2] = '{1'b0, 409'hF,  409'hF,  817'h55};
        vt[3].id = 1'b1;
        vt[3].a  = 409'd1 << 408;
        vt[3].b  = 409'd2;
`ifdef KA409_REDUCE_EN
        vt[3].y  = (817'd1 << 87) | 817'd1;
`else
        vt[3].y  = 817'd1 << 409;
`endif
        for (int i = 4; i < 8; i++) begin
            vt[i].id = i[0];
            for (int w = 0; w < 13; w++) begin
                vt[i].a[w*32 +: 32] = $urandom;
                vt[i].b[w*32 +: 32] = $urandom;
            end
            vt[i].a[408:384] = 25'($urandom);
            vt[i].b[408:384] = 25'($urandom);
            if (i == 4) vt[i].a = '1;
            vt[i].y = ref_y(vt[i].a, vt[i].b);
        end

        repeat (2) @(posedge clk);
        #1;
        chki("rst_rdy0", int'(req0_ready), 0);
        chki("rst_rdy1", int'(req1_ready), 0);
        chki("rst_rsp_valid", int'(rsp_valid), 0);
        chki("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_y", rsp_y, 817'd0);
        chki("rst_busy", int'(busy), 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            do_op(vt[i], 2);

        // Contention from reset: grants must alternate starting with requester 0.
        pulse_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 409'd1; req0_b = 409'd6; req1_a = 409'd1; req1_b = 409'd6;
        for (int i = 0; i < 100 && glog.size() < 4; i++) begin
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chki("rr_drain", sb.size(), 0);
        chki("rr_count", glog.size(), 4);
        if (glog.size() >= 4)
            for (int i = 0; i < 4; i++)
                chki("rr_order", int'(glog[i]), i % 2);

        // Held response with operands changed after accept and a request arriving in DONE.
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 409'd5; req1_b = 409'd3;
        wait_rdy(1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0; req1_a = 409'd9; req1_b = 409'd7;
        wait_rsp(n);
        chki("hold_lat", n, 2);
        req0_valid = 1'b1; req0_a = 409'd3; req0_b = 409'd3;
        for (int i = 0; i < 5; i++) begin
            chki("hold_valid", int'(rsp_valid), 1);
            chk("hold_y", rsp_y, 817'd15);
            chki("hold_id", int'(rsp_id), 1);
            @(negedge clk);
            chki("hold_rdy0", int'(req0_ready), 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chki("done_rdy0", int'(req0_ready), 0);
        @(posedge clk); #1;
        chki("post_rsp_valid", int'(rsp_valid), 0);
        chki("post_busy", int'(busy), 0);
        @(negedge clk);
        chki("idle_rdy0", int'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(n);
        chki("next_lat", n, 2);
        @(posedge clk); #1;

        // Reset during MUL aborts the operation.
        req0_valid = 1'b1; req0_a = 409'd3; req0_b = 409'd3;
        wait_rdy(1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chki("mul_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chki("abort_busy", int'(busy), 0);
        chki("abort_valid", int'(rsp_valid), 0);
        #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chki("abort_no_rsp", int'(rsp_valid), 0);
        end
        do_op(vt[0], 2);

        lat_test(0, 1);
        lat_test(1, 16);

        chki("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ka409_mul_sched.md
# ka409_mul_sched

Scheduler that shares one combinational `KA_409bit` Karatsuba multiplier between two requesters. It arbitrates between the requesters round-robin and registers the winning operands. It then holds those operands stable for a fixed multi-cycle window while the 409-bit carry-less (GF(2)[x]) product settles, captures the 817-bit product, and returns it on a single tagged response channel. It sits between the ECC point-arithmetic engines and the multiplier datapath.

## Interface
- `MUL_CYCLES`, default 2: clock cycles allotted to the multiplier multi-cycle path; legal range 1..16.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  requester 0 has an operand pair
- `req0_ready`  out  1  requester 0 operands accepted this cycle
- `req0_a`, `req0_b`  in  409 each  requester 0 operands
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer takes the result
- `rsp_id`  out  1  requester that owns the result
- `rsp_y`  out  817  product
- `busy`  out  1  state is not IDLE

## Operation
- FSM states:
  - IDLE:
    - If any `reqN_valid` is high, grant one requester.
    - Latch `a`, `b` and the id into the operand registers.
    - Load `cnt = MUL_CYCLES-1`, then go to MUL.
  - MUL:
    - Operand registers drive `KA_409bit`.
    - Each cycle: if `cnt == 0`, capture the product into `rsp_y` and go to DONE; otherwise decrement `cnt`.
  - DONE:
    - Hold `rsp_valid = 1`.
    - On `rsp_valid && rsp_ready`, go to IDLE.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester not served last wins.
  - The `last` register resets to 1, so requester 0 wins the first tie.
- `reqN_ready = (state == IDLE) && grantN`. Ready may depend on valid. At most one ready is high per cycle.
- Operands are sampled only at the accept edge. Input changes after that edge do not affect the result.
- Product width rule: `y[816:0] = a(x)·b(x)` over GF(2), with no carries.
- The response payload (`rsp_y`, `rsp_id`) is stable while `rsp_valid && !rsp_ready`.
- Requests arriving while busy stall with ready low. They are not dropped.

## Timing
- Reset values:
  - state = IDLE
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_y` = 0
  - `busy` = 0, `last` = 1, `cnt` = 0
  - both readies = 0
- Latency: with the accept at edge e0, `rsp_valid` rises after edge e(MUL_CYCLES).
- Throughput: if `rsp_ready` is held high, one operation every MUL_CYCLES+2 cycles. The cycle after the response handshake is IDLE, so the next accept can occur at that cycle's edge.
- Back-to-back contention alternates between requesters: 0, 1, 0, 1...
- Reset mid-operation aborts the operation: no response, the state returns to IDLE, and the granted requester must reissue.
- Simultaneous `rsp_ready` and new `req_valid` in DONE: only the response completes. The new request is accepted in the following IDLE cycle.

## Configuration
- `KA409_REDUCE_EN`:
  - Defined: the captured value is the product reduced modulo the B-409 trinomial x^409 + x^87 + 1. `rsp_y[408:0]` holds the field element and `rsp_y[816:409]` = 0. Reduction is combinational, inside the same MUL window; latency is unchanged.
  - Undefined: `rsp_y` is the raw 817-bit product.

## Structure
- Package `ka409_pkg` holds:
  - constants `KA_N = 409`, `KA_YW = 817`, `KA_RED_K = 87`
  - the FSM state enum (IDLE, MUL, DONE)
- Shared multiplier: one instance of the existing `KA_409bit`.
- Sub-module `ka409_reduce`: trinomial folding reduction, instantiated only under `KA409_REDUCE_EN`.
- Top-level RTL holds the arbiter, FSM, counter and registers.

## Test plan
- Reset, then req0 with a = 3, b = 3 and MUL_CYCLES = 2 → accepted, `rsp_valid` rises 2 edges later, `rsp_y` = 5, `rsp_id` = 0.
- Both valid from reset, a = 1, b = 6 on both → grant order 0, 1, 0, 1 across four operations; every `rsp_y` = 6.
- Operand changed the cycle after accept, `rsp_ready` held low for 5 cycles → `rsp_y`/`rsp_id` stable for all 5 cycles, result from the original operands.
- a = 2^408, b = 2:
  - Without the macro → `rsp_y` = 2^409.
  - With `KA409_REDUCE_EN` → `rsp_y` = 2^87 + 1.
- `rst` pulsed during MUL → no `rsp_valid`; `busy` = 0; the next request completes normally.
- MUL_CYCLES = 1 and MUL_CYCLES = 16 → `rsp_valid` rises exactly 1 and 16 edges after accept respectively.
